ula_param_seq: RTL
==================

ULA_PARAM_SEQ -- requirements
Module: ula_param_seq

Interface
REQ-001 Parameter: WIDTH, 6, operand/result width in bits (legal >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: start  input  1  request pulse; accepted only when busy=0.
REQ-005 Port: modo  input  1  mode select: 1 = logic, 0 = arithmetic.
REQ-006 Port: op_sel  input  3  operation select within mode.
REQ-007 Port: A  input  WIDTH  operand A, unsigned.
REQ-008 Port: B  input  WIDTH  operand B, unsigned.
REQ-009 Port: O  output  WIDTH  registered result.
REQ-010 Port: carry_out  output  1  registered carry/borrow/overflow flag.
REQ-011 Port: zero  output  1  registered flag, 1 when O == 0.
REQ-012 Port: busy  output  1  high while a multi-cycle operation is in progress.
REQ-013 Port: done  output  1  one-cycle pulse when O/carry_out/zero update.

Function
REQ-014 The block SHALL capture A, B, modo and op_sel on the clock edge where start=1 and busy=0 (accept edge N); later input changes SHALL NOT affect the operation in flight.
REQ-015 The FSM SHALL have states IDLE and MUL; all operations except MUL execute from IDLE with no state change.
REQ-016 Logic mode (modo=1): op_sel 000 A&B, 001 A|B, 010 A^B, 011 ~A, 100-111 O=0; carry_out=0.
REQ-017 Arithmetic mode (modo=0): 000 ADD A+B, carry_out = bit WIDTH of the sum.
REQ-018 Arithmetic 001 SUB: O = (A-B) mod 2^WIDTH, carry_out = 1 iff A < B (borrow).
REQ-019 Arithmetic 010 INC: O = (A+1) mod 2^WIDTH, carry_out = 1 iff A = 2^WIDTH-1.
REQ-020 Arithmetic 011 DEC: O = (A-1) mod 2^WIDTH, carry_out = 1 iff A = 0.
REQ-021 Arithmetic 100 MUL: unsigned shift-add, one multiplier bit per cycle; O = low WIDTH bits of A*B, carry_out = 1 iff upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-022 Arithmetic 101-111: O=0, carry_out=0, single-cycle.
REQ-023 Single-cycle ops: O, carry_out, zero SHALL update on edge N+1 (visible after it) with done=1 for that one cycle; busy stays 0.
REQ-024 MUL: busy=1 from after edge N until after edge N+WIDTH; results and done=1 SHALL appear after edge N+WIDTH, busy returning to 0 on the same edge; FSM returns to IDLE.
REQ-025 start while busy=1 SHALL be ignored (no capture, no queuing).
REQ-026 start on the same edge MUL completes SHALL be ignored; a new start is accepted from the following cycle.
REQ-027 zero SHALL be recomputed from the new O on every completion.
REQ-028 O, carry_out, zero SHALL hold their values between completions.
REQ-029 done SHALL never be high for two consecutive cycles from the same operation.

Reset
REQ-030 On reset=1 at an edge: O=0, carry_out=0, zero=1, busy=0, done=0, FSM=IDLE, internal accumulator/operand registers cleared.
REQ-031 reset SHALL take priority over start and over an in-flight MUL; an aborted MUL SHALL produce no done pulse.
REQ-032 start asserted together with reset SHALL be ignored.

Verification (WIDTH=6)
REQ-033 modo=1, op_sel=000, A=0x2A, B=0x0F, start at N -> after N+1: O=0x0A, carry_out=0, zero=0, done=1 one cycle.
REQ-034 modo=0, op_sel=000, A=63, B=1 -> O=0, carry_out=1, zero=1; then op_sel=001, A=5, B=7 -> O=62, carry_out=1, zero=0.
REQ-035 modo=0, op_sel=100, A=9, B=8, start at N -> busy=1 cycles N+1..N+6, after N+6: O=8, carry_out=1, done=1; start pulsed at N+3 with other operands ignored.
REQ-036 MUL A=9, B=8 started, reset at N+3 -> O=0, carry_out=0, zero=1, busy=0, no done pulse ever for that operation.
REQ-037 modo=1, op_sel=011, A=0 -> O=63, zero=0; then modo=1, op_sel=111 -> O=0, zero=1, carry_out=0.
REQ-038 Back-to-back single-cycle starts on consecutive cycles -> each accepted, done high both cycles, O tracks each result in order.

Source files
------------

// File: rtl/ula_param_seq.sv
// ula_param_seq: registered logic/arithmetic unit with a one-bit-per-cycle shift-add multiplier.
module ula_param_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             modo,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, o_q, o_d;
  logic [2:0] op_q;
  logic modo_q, pend_q, c_q, c_d, z_q, done_q, accept, is_mul, mul_last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH:0] ax, bx, alu;
  assign accept = start && state_q == IDLE;
  assign is_mul = !modo && op_sel == 3'b100;
  assign mul_last = state_q == MUL && cnt_q == LAST;
  // Arithmetic ops run one bit wider so bit WIDTH is the carry or borrow.
  always_comb begin
    ax = {1'b0, a_q};
    bx = {1'b0, b_q};
    alu = modo_q ? (op_q == 3'd0 ? ax & bx : op_q == 3'd1 ? ax | bx : op_q == 3'd2 ? ax ^ bx :
                    op_q == 3'd3 ? {1'b0, ~a_q} : '0)
                 : (op_q == 3'd0 ? ax + bx : op_q == 3'd1 ? ax - bx : op_q == 3'd2 ? ax + ONE :
                    op_q == 3'd3 ? ax - ONE : '0);
    prod = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
    state_d = (accept && is_mul) ? MUL : mul_last ? IDLE : state_q;
    acc_d = accept ? '0 : state_q == MUL ? prod : acc_q;
    cnt_d = accept ? '0 : state_q == MUL ? cnt_q + 1'b1 : cnt_q;
    o_d = mul_last ? prod[WIDTH-1:0] : pend_q ? alu[WIDTH-1:0] : o_q;
    c_d = mul_last ? |prod[2*WIDTH-1:WIDTH] : pend_q ? alu[WIDTH] : c_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      modo_q <= 1'b0;
      op_q <= '0;
      pend_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      o_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= A;
        b_q <= B;
        modo_q <= modo;
        op_q <= op_sel;
      end
      state_q <= state_d;
      pend_q <= accept && !is_mul;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      o_q <= o_d;
      c_q <= c_d;
      z_q <= o_d == '0;
      done_q <= pend_q || mul_last;
    end
  end
  assign O = o_q;
  assign carry_out = c_q;
  assign zero = z_q;
  assign busy = state_q == MUL;
  assign done = done_q;
endmodule
